// File: rtl/tt_pkg.sv
// tt_pkg: shared sizes, FSM state encoding and pattern index type for the truth-table sweeper
package tt_pkg;
  localparam int NUM_IN = 7;
  localparam int TT_W = 2 ** NUM_IN;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;
  typedef logic [NUM_IN-1:0] idx_t;
endpackage

// File: rtl/tt_sweep_collector_if.sv
// tt_sweep_collector_if: control, pattern drive and result bundle between collector and its user
interface tt_sweep_collector_if #(parameter int NUM_IN = tt_pkg::NUM_IN);
  localparam int TT_W = 2 ** NUM_IN;
  logic start;
  logic abort;
  logic f_out;
  logic res_ready;
  logic [NUM_IN-1:0] pat;
  logic pat_valid;
  logic busy;
  logic res_valid;
  logic [TT_W-1:0] tt;
  logic [NUM_IN:0] ones;
  modport master (input start, abort, f_out, res_ready, output pat, pat_valid, busy, res_valid, tt, ones);
  modport slave (output start, abort, f_out, res_ready, input pat, pat_valid, busy, res_valid, tt, ones);
endinterface

// File: rtl/tt_idx_delay.sv
// tt_idx_delay: LAT-deep {valid, idx} shift pipeline aligning pattern indices with a registered DUT
module tt_idx_delay #(
  parameter int W = 7,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_v,
  input  logic [W-1:0] in_idx,
  output logic         out_v,
  output logic [W-1:0] out_idx
);
  if (LAT == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, clr};
    assign out_v = in_v;
    assign out_idx = in_idx;
  end else begin : g_pipe
    logic [LAT-1:0] v_q, v_d;
    logic [W-1:0] idx_q [LAT];
    logic [W-1:0] idx_d [LAT];
    // shift one stage per cycle; clr kills every in-flight valid
    always_comb begin
      v_d[0] = in_v & ~clr;
      idx_d[0] = in_idx;
      for (int i = 1; i < LAT; i++) begin
        v_d[i] = v_q[i-1] & ~clr;
        idx_d[i] = idx_q[i-1];
      end
    end
    // pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
      end else begin
        v_q <= v_d;
        for (int i = 0; i < LAT; i++) idx_q[i] <= idx_d[i];
      end
    end
    assign out_v = v_q[LAT-1];
    assign out_idx = idx_q[LAT-1];
  end
endmodule

// File: rtl/tt_sweep_collector.sv
// tt_sweep_collector: sweeps all input patterns through a function and packs its outputs into a truth table
module tt_sweep_collector
  import tt_pkg::*;
#(
  parameter int LAT = 0
) (
  input logic clk,
  input logic rst_n,
  tt_sweep_collector_if.master bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SWEEP = SWEEP;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam idx_t PAT_LAST = idx_t'(TT_W - 1);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(LAT > 0 ? LAT - 1 : 0);

  logic [1:0] state_q, state_d;
  idx_t pat_q, pat_d;
  logic pat_valid_q, pat_valid_d;
  logic busy_q, busy_d;
  logic res_valid_q, res_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [NUM_IN:0] ones_q, ones_d;
  logic abort_now, ack, clr, cap_v;
  idx_t cap_idx;

  assign abort_now = bus.abort && state_q != ST_IDLE;
  assign ack = res_valid_q && bus.res_ready;

  tt_idx_delay #(.W(NUM_IN), .LAT(LAT)) u_delay (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .in_v(pat_valid_q),
    .in_idx(pat_q),
    .out_v(cap_v),
    .out_idx(cap_idx)
  );

  // sweep FSM: pattern counter, drain timer and result handshake; abort wins over everything
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    pat_valid_d = 1'b0;
    res_valid_d = 1'b0;
    cnt_d = cnt_q;
    clr = 1'b0;
    if (abort_now) begin
      state_d = ST_IDLE;
      pat_d = '0;
      clr = 1'b1;
    end else if (state_q == ST_IDLE) begin
      if (bus.start) begin
        state_d = ST_SWEEP;
        pat_d = '0;
        pat_valid_d = 1'b1;
        clr = 1'b1;
      end
    end else if (state_q == ST_SWEEP) begin
      pat_d = pat_q + 1'b1;
      cnt_d = '0;
      pat_valid_d = pat_q != PAT_LAST;
      if (pat_q == PAT_LAST) state_d = LAT > 0 ? ST_DRAIN : ST_DONE;
    end else if (state_q == ST_DRAIN) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == DRAIN_LAST) state_d = ST_DONE;
    end else begin
      res_valid_d = !ack;
      if (ack) state_d = ST_IDLE;
    end
    busy_d = state_d == ST_SWEEP || state_d == ST_DRAIN;
  end

  // capture by delayed index so bit placement is independent of latency
  always_comb begin
    tt_d = clr ? '0 : tt_q;
    ones_d = clr ? '0 : ones_q;
    if (!clr && cap_v) begin
      tt_d[cap_idx] = bus.f_out;
      ones_d = ones_q + (NUM_IN + 1)'(bus.f_out);
    end
  end

  // state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q <= '0;
      pat_valid_q <= 1'b0;
      busy_q <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_q <= '0;
      tt_q <= '0;
      ones_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      pat_valid_q <= pat_valid_d;
      busy_q <= busy_d;
      res_valid_q <= res_valid_d;
      cnt_q <= cnt_d;
      tt_q <= tt_d;
      ones_q <= ones_d;
    end
  end

  assign bus.pat = pat_q;
  assign bus.pat_valid = pat_valid_q;
  assign bus.busy = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.tt = tt_q;
  assign bus.ones = ones_q;
endmodule

// File: tb/tb_tt_sweep_collector.sv
// tb_tt_sweep_collector: directed sweeps on a combinational and a twice-registered function
module tb_tt_sweep_collector;
  typedef struct {
    int fs;
    logic [127:0] tt;
    int ones;
    int hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int fsel = 0;
  logic [6:0] d1 = '0;
  logic [6:0] d2 = '0;
  vec_t tbl [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_collector_if b0 ();
  tt_sweep_collector_if b2 ();

  tt_sweep_collector #(.LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  tt_sweep_collector #(.LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.master));

  function automatic logic fn(input int s, input logic [6:0] p);
    case (s)
      0: return 1'b0;
      1: return p[0];
      2: return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
      3: return &p;
      4: return p[6];
      default: return ^p;
    endcase
  endfunction

  always @(posedge clk) begin
    d1 <= b2.pat;
    d2 <= d1;
  end
  assign b0.f_out = fn(fsel, b0.pat);
  assign b2.f_out = fn(fsel, d2);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic r);
    b0.start = s;
    b2.start = s;
    b0.abort = a;
    b2.abort = a;
    b0.res_ready = r;
    b2.res_ready = r;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_sweep(input vec_t v);
    int k, r0, r2, pv, dr, n;
    fsel = v.fs;
    r0 = 0;
    r2 = 0;
    pv = 0;
    dr = 0;
    n = 0;
    pulse_start();
    k = cyc;
    chk("first_pat", 128'({b0.pat_valid, b0.busy, b0.pat}), 128'({2'b11, 7'd0}));
    while ((r0 == 0 || r2 == 0) && n < 400) begin
      pv += int'(b0.pat_valid);
      if (b2.busy && !b2.pat_valid) dr++;
      if (b0.res_valid && r0 == 0) r0 = cyc;
      if (b2.res_valid && r2 == 0) r2 = cyc;
      @(negedge clk);
      n++;
    end
    chk("rv_lat0", 128'(r0 - k), 128'(129));
    chk("rv_lat2", 128'(r2 - k), 128'(131));
    chk("pv_cycles", 128'(pv), 128'(128));
    chk("drain_cycles", 128'(dr), 128'(2));
    chk("tt_lat0", b0.tt, v.tt);
    chk("ones_lat0", 128'(b0.ones), 128'(v.ones));
    chk("tt_lat2", b2.tt, v.tt);
    chk("ones_lat2", 128'(b2.ones), 128'(v.ones));
    for (int i = 0; i < v.hold; i++) begin
      b0.start = i[0];
      b2.start = i[0];
      @(negedge clk);
      chk("hold_rv", 128'({b0.res_valid, b2.res_valid}), 128'(2'b11));
      chk("hold_tt", b0.tt ^ b2.tt ^ v.tt, v.tt);
      chk("hold_ones", 128'({b0.ones, b2.ones}), 128'({v.ones[7:0], v.ones[7:0]}));
    end
    drive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    chk("ack_idle", 128'({b0.res_valid, b2.res_valid, b0.busy, b2.busy}), 128'(0));
    chk("retain_tt", b2.tt, v.tt);
    @(negedge clk);
    chk("still_idle", 128'({b0.busy, b2.busy, b0.pat_valid, b2.pat_valid}), 128'(0));
  endtask

  initial begin
    int n, seen;
    tbl[0] = '{0, 128'h0, 0, 0};
    tbl[1] = '{1, {8{16'hAAAA}}, 64, 0};
    tbl[2] = '{2, {16{8'hE8}}, 64, 0};
    tbl[3] = '{3, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1, 10};
    tbl[4] = '{4, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 64, 0};
    tbl[5] = '{5, {64'h9669_6996_6996_9669, 64'h6996_9669_9669_6996}, 64, 0};
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_ctl", 128'({b0.pat_valid, b0.busy, b0.res_valid, b2.pat_valid, b2.busy, b2.res_valid}), 128'(0));
    chk("rst_data", 128'({b0.pat, b0.ones, b2.pat, b2.ones}), 128'(0));
    chk("rst_tt", b0.tt | b2.tt, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    chk("idle_abort", 128'({b0.busy, b2.busy, b0.pat_valid}), 128'(0));

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    fsel = 1;
    pulse_start();
    n = 0;
    while (b0.pat != 7'd40 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", 128'(n < 100), 128'(1));
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    chk("abort_ctl", 128'({b0.pat_valid, b0.busy, b0.res_valid, b2.pat_valid, b2.busy, b2.res_valid}), 128'(0));
    chk("abort_tt", b0.tt | b2.tt, 128'h0);
    chk("abort_ones", 128'({b0.ones, b2.ones}), 128'(0));
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (b0.res_valid || b2.res_valid || b0.busy) seen++;
    end
    chk("abort_quiet", 128'(seen), 128'(0));
    run_sweep(tbl[1]);

    fsel = 2;
    pulse_start();
    n = 0;
    while (!(b2.busy && !b2.pat_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_reach", 128'(n < 300), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 128'({b0.pat_valid, b0.busy, b0.res_valid, b2.pat_valid, b2.busy, b2.res_valid}), 128'(0));
    chk("mid_rst_data", 128'({b0.pat, b0.ones, b2.pat, b2.ones}), 128'(0));
    chk("mid_rst_tt", b0.tt | b2.tt, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(tbl[2]);
    run_sweep(tbl[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
